operand_serializer: RTL and testbench

Upstream feeder for the bit-serial adder FSM. Accepts two parallel WIDTH-bit operands and an initial carry over a valid/ready handshake. Drives start, A, B and CIN to the adder one bit per cycle, LSB first. Optionally closes the carry loop by feeding the adder's COUT back into CIN on each following bit.

---
 rtl/operand_serializer.sv | 138 +++++++++++++
 tb/tb_operand_serializer.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/operand_serializer.sv
// Parallel-to-serial operand feeder for the bit-serial adder: captures A/B/carry on a
// valid/ready handshake and streams them LSB first. Optional build macro: CARRY_FB_EN.
module operand_serializer #(
    parameter int WIDTH = 8
) (
    input  logic             CLK,
    input  logic             NRST,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             cin_init,
    input  logic             abort,
    input  logic             cout_fb,
    output logic             start,
    output logic             A,
    output logic             B,
    output logic             CIN,
    output logic             busy,
    output logic             done
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] sr_a;
    logic [WIDTH-1:0] sr_b;
    logic [CW-1:0]    cnt;
    logic             capture;
    logic             advance;
    logic             finish;
    logic             carry_next;

`ifdef CARRY_FB_EN
    assign carry_next = cout_fb;
`else
    logic unused_cout_fb;
    assign unused_cout_fb = cout_fb;
    assign carry_next     = 1'b0;
`endif

    always_ff @(posedge CLK or negedge NRST) begin
        if (!NRST) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // cnt holds the number of bits still to be presented after the current one
    always_comb begin
        state_next = state;
        capture    = 1'b0;
        advance    = 1'b0;
        finish     = 1'b0;
        if (abort) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        capture    = 1'b1;
                        state_next = START;
                    end
                end
                START, SHIFT: begin
                    if (cnt == '0) begin
                        finish     = 1'b1;
                        state_next = DONE;
                    end else begin
                        advance    = 1'b1;
                        state_next = SHIFT;
                    end
                end
                DONE:    state_next = IDLE;
                default: state_next = IDLE;
            endcase
        end
    end

    assign in_ready = (state == IDLE);
    assign busy     = (state == START) || (state == SHIFT);

    // Bit 0 is loaded straight into the output flops at capture, so the shift
    // registers keep only the remaining upper bits.
    always_ff @(posedge CLK or negedge NRST) begin
        if (!NRST) begin
            sr_a  <= '0;
            sr_b  <= '0;
            cnt   <= '0;
            start <= 1'b0;
            A     <= 1'b0;
            B     <= 1'b0;
            CIN   <= 1'b0;
            done  <= 1'b0;
        end else begin
            start <= 1'b0;
            done  <= 1'b0;
            if (abort) begin
                sr_a <= '0;
                sr_b <= '0;
                cnt  <= '0;
                A    <= 1'b0;
                B    <= 1'b0;
                CIN  <= 1'b0;
            end else if (capture) begin
                sr_a  <= op_a >> 1;
                sr_b  <= op_b >> 1;
                cnt   <= CW'(WIDTH - 1);
                A     <= op_a[0];
                B     <= op_b[0];
                CIN   <= cin_init;
                start <= 1'b1;
            end else if (advance) begin
                sr_a <= sr_a >> 1;
                sr_b <= sr_b >> 1;
                cnt  <= cnt - 1'b1;
                A    <= sr_a[0];
                B    <= sr_b[0];
                CIN  <= carry_next;
            end else if (finish) begin
                A    <= 1'b0;
                B    <= 1'b0;
                CIN  <= 1'b0;
                done <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_operand_serializer.sv
// Scoreboard bench for operand_serializer (WIDTH=8): stimulus queues expected per-cycle
// output records, a negedge monitor pops and compares them whenever busy or done is high.
module tb_operand_serializer;

    localparam int W = 8;
`ifdef CARRY_FB_EN
    localparam bit FB = 1'b1;
`else
    localparam bit FB = 1'b0;
`endif

    logic         CLK = 1'b0;
    logic         NRST;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] op_a;
    logic [W-1:0] op_b;
    logic         cin_init;
    logic         abort;
    logic         cout_fb;
    logic         start;
    logic         A;
    logic         B;
    logic         CIN;
    logic         busy;
    logic         done;

    operand_serializer #(.WIDTH(W)) dut (
        .CLK     (CLK),
        .NRST    (NRST),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .op_a    (op_a),
        .op_b    (op_b),
        .cin_init(cin_init),
        .abort   (abort),
        .cout_fb (cout_fb),
        .start   (start),
        .A       (A),
        .B       (B),
        .CIN     (CIN),
        .busy    (busy),
        .done    (done)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic st;
        logic a;
        logic b;
        logic c;
        logic bz;
        logic dn;
    } rec_t;

    rec_t q[$];
    rec_t mon_r;
    int   passed = 0;
    int   total  = 0;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    task automatic cyc();
        @(posedge CLK);
        #1;
    endtask

    // Expected records for the first n bits, optionally followed by the done cycle.
    task automatic push_bits(input logic [W-1:0] a, input logic [W-1:0] b,
                             input logic c, input logic f, input int n, input bit with_done);
        rec_t r;
        for (int k = 0; k < n; k++) begin
            r.st = (k == 0);
            r.a  = a[k];
            r.b  = b[k];
            r.c  = (k == 0) ? c : (FB & f);
            r.bz = 1'b1;
            r.dn = 1'b0;
            q.push_back(r);
        end
        if (with_done) begin
            r = '0;
            r.dn = 1'b1;
            q.push_back(r);
        end
    endtask

    // Called in the T0 cycle with the block idle.
    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic c, input logic f, input bit hold_valid);
        chk("ready_T0", in_ready, 1'b1);
        op_a     = a;
        op_b     = b;
        cin_init = c;
        cout_fb  = f;
        in_valid = 1'b1;
        push_bits(a, b, c, f, W, 1'b1);
        for (int t = 1; t <= W + 1; t++) begin
            cyc();
            if (hold_valid) begin
                op_a     = W'($urandom);
                op_b     = W'($urandom);
                cin_init = 1'($urandom);
            end else begin
                in_valid = 1'b0;
            end
            chk("ready_low_busy", in_ready, 1'b0);
        end
        cyc();
        chk("ready_T10", in_ready, 1'b1);
    endtask

    always @(negedge CLK) begin
        if (busy || done) begin
            if (q.size() == 0) begin
                total++;
                $display("FAIL unexpected_output: start=%b A=%b B=%b CIN=%b busy=%b done=%b expected none at %0t",
                         start, A, B, CIN, busy, done, $time);
            end else begin
                mon_r = q.pop_front();
                chk("start", start, mon_r.st);
                chk("A", A, mon_r.a);
                chk("B", B, mon_r.b);
                chk("CIN", CIN, mon_r.c);
                chk("busy", busy, mon_r.bz);
                chk("done", done, mon_r.dn);
            end
        end else begin
            chk("idle_outputs", {4'h0, start, A, B, CIN}, 8'h00);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected finish before 200000");
        $fatal(1, "watchdog");
    end

    initial begin
        NRST = 1'b0;
        in_valid = 1'b0; op_a = '0; op_b = '0; cin_init = 1'b0; abort = 1'b0; cout_fb = 1'b0;

        // Reset with random inputs
        for (int i = 0; i < 4; i++) begin
            op_a = W'($urandom); op_b = W'($urandom); in_valid = 1'($urandom);
            cin_init = 1'($urandom); cout_fb = 1'($urandom); abort = 1'($urandom);
            cyc();
            chk("rst_outs", {2'b0, start, A, B, CIN, done, busy}, 8'h00);
            chk("rst_ready", in_ready, 1'b1);
        end
        in_valid = 1'b0; abort = 1'b0; cout_fb = 1'b0; cin_init = 1'b0;
        #2 NRST = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("post_rst_idle", {start, busy, done, in_ready}, 4'b0001);
        end

        // Basic word
        send(8'h5A, 8'h3C, 1'b0, 1'b0, 1'b0);
        // Carry feedback with cout_fb tied high
        send(8'hFF, 8'h01, 1'b1, 1'b1, 1'b0);
        // Busy rejection, then a capture in T10
        send(8'hA5, 8'h0F, 1'b1, 1'b0, 1'b1);
        send(8'h81, 8'h7E, 1'b0, 1'b1, 1'b0);

        // Abort in T4
        chk("ready_abort_T0", in_ready, 1'b1);
        op_a = 8'hC3; op_b = 8'h96; cin_init = 1'b1; cout_fb = 1'b0; in_valid = 1'b1;
        push_bits(8'hC3, 8'h96, 1'b1, 1'b0, 4, 1'b0);
        cyc(); in_valid = 1'b0;
        cyc(); cyc(); cyc();
        abort = 1'b1;
        cyc(); abort = 1'b0;
        chk("abort_state", {A, B, CIN, busy, done, in_ready}, 8'b000001);
        cyc();
        chk("abort_stay_idle", {busy, done, in_ready}, 3'b001);

        // Abort together with in_valid in IDLE
        abort = 1'b1; in_valid = 1'b1; op_a = 8'hFF; op_b = 8'hFF;
        chk("abort_idle_ready", in_ready, 1'b1);
        cyc(); abort = 1'b0; in_valid = 1'b0;
        chk("abort_no_capture", {start, busy, in_ready}, 3'b001);
        cyc();
        chk("abort_no_capture2", {busy, in_ready}, 2'b01);

        // Async reset mid-SHIFT in T5
        op_a = 8'h3C; op_b = 8'hE7; cin_init = 1'b1; cout_fb = 1'b1; in_valid = 1'b1;
        push_bits(8'h3C, 8'hE7, 1'b1, 1'b1, 4, 1'b0);
        cyc(); in_valid = 1'b0;
        cyc(); cyc(); cyc();
        cyc();
        #1 NRST = 1'b0;
        #1 chk("async_rst_outs", {2'b0, start, A, B, CIN, done, busy}, 8'h00);
        chk("async_rst_ready", in_ready, 1'b1);
        cyc(); cyc();
        #2 NRST = 1'b1;
        cyc();
        send(8'h5A, 8'h3C, 1'b1, 1'b0, 1'b0);

        cyc(); cyc();
        chk("queue_empty", 8'(q.size()), 8'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
